// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared definitions for the byte-serial RV32M multiply path:
//                op encodings, controller state codes and word geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // Operation select, equal to funct3[1:0] of the RV32M multiply group
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    // Controller state codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int BYTES_PER_WORD = 4;

    // Magnitude of a 32-bit value; 0x80000000 maps to itself (read as unsigned)
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_byte_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : mul_byte_datapath
//  Description : 32x8 partial-product datapath. Selects byte i_cnt of the
//                multiplier magnitude by a byte-granular left rotate, forms
//                the 40-bit partial product and adds it, shifted by
//                8*i_cnt, into the 64-bit accumulator (the only register).
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_byte_datapath
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_acc_clr,
    input  logic        i_acc_en,
    input  logic [31:0] i_abs_a,
    input  logic [31:0] i_abs_b,
    input  logic [1:0]  i_cnt,
    output logic [63:0] o_acc
);

    logic [63:0] r_acc;
    logic [1:0]  w_rot_amt;
    logic [5:0]  w_rot_sh;
    logic [31:0] w_rot;
    logic [7:0]  w_byte;
    logic [39:0] w_partial;
    logic [63:0] w_term;

    // Rotating left by ((4-cnt) mod 4) bytes brings byte cnt to the bottom
    assign w_rot_amt = 2'(BYTES_PER_WORD) - i_cnt;
    assign w_rot_sh  = {1'b0, w_rot_amt, 3'b000};
    // A zero rotate makes the right shift 32, which yields zero as required
    assign w_rot     = (i_abs_b << w_rot_sh) | (i_abs_b >> (6'd32 - w_rot_sh));
    assign w_byte    = 8'(w_rot);

    assign w_partial = {8'd0, i_abs_a} * {32'd0, w_byte};
    assign w_term    = {24'd0, w_partial} << {i_cnt, 3'b000};

    // Accumulator: cleared on request acceptance, accumulates one byte per ITER cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= 64'd0;
        end else if (i_acc_clr) begin
            r_acc <= 64'd0;
        end else if (i_acc_en) begin
            r_acc <= r_acc + w_term;
        end
    end

    assign o_acc = r_acc;

endmodule : mul_byte_datapath
`default_nettype wire

// File: rtl/mul_byte_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mul_byte_seq
//  Description : Byte-serial RV32M MUL/MULH/MULHSU/MULHU controller. Takes
//                operand magnitudes and result sign at acceptance, walks the
//                four multiplier bytes through mul_byte_datapath, applies the
//                sign and returns the selected 32-bit half over valid/ready.
//                Optional macro MUL_EARLY_EXIT_EN: leave ITER as soon as all
//                remaining multiplier bytes are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_byte_seq
    import mul_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o
);

    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic [1:0]  r_op;
    logic        r_neg;
    logic [31:0] r_abs_a;
    logic [31:0] r_abs_b;
    logic [31:0] r_result;
    logic        r_valid;

    logic        w_sign_a;
    logic        w_sign_b;
    logic        w_accept;
    logic        w_last;
    logic [63:0] w_acc;
    logic [63:0] w_prod;

    // a is signed for MULH/MULHSU, b only for MULH
    assign w_sign_a = ((op_i == MUL_OP_MULH) || (op_i == MUL_OP_MULHSU)) && operand_a_i[31];
    assign w_sign_b = (op_i == MUL_OP_MULH) && operand_b_i[31];
    assign w_accept = valid_i && (r_state == ST_IDLE);

`ifdef MUL_EARLY_EXIT_EN
    logic w_upper_zero;

    // True when every multiplier byte above the current one is zero
    always_comb begin
        w_upper_zero = 1'b1;
        case (r_cnt)
            2'd0:    w_upper_zero = (r_abs_b[31:8]  == 24'd0);
            2'd1:    w_upper_zero = (r_abs_b[31:16] == 16'd0);
            2'd2:    w_upper_zero = (r_abs_b[31:24] == 8'd0);
            default: w_upper_zero = 1'b1;
        endcase
    end

    assign w_last = w_upper_zero;
`else
    assign w_last = (r_cnt == 2'd3);
`endif

    mul_byte_datapath u_datapath (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .i_acc_clr (w_accept),
        .i_acc_en  (r_state == ST_ITER),
        .i_abs_a   (r_abs_a),
        .i_abs_b   (r_abs_b),
        .i_cnt     (r_cnt),
        .o_acc     (w_acc)
    );

    assign w_prod = r_neg ? (~w_acc + 64'd1) : w_acc;

    // Controller: accept, iterate over bytes, sign-fix, hold result until taken
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 2'd0;
            r_op     <= MUL_OP_MUL;
            r_neg    <= 1'b0;
            r_abs_a  <= 32'd0;
            r_abs_b  <= 32'd0;
            r_result <= 32'd0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        r_abs_a <= abs32(operand_a_i, w_sign_a);
                        r_abs_b <= abs32(operand_b_i, w_sign_b);
                        r_neg   <= w_sign_a ^ w_sign_b;
                        r_op    <= op_i;
                        r_cnt   <= 2'd0;
                        r_state <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (w_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result <= (r_op == MUL_OP_MUL) ? w_prod[31:0] : w_prod[63:32];
                    r_valid  <= 1'b1;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_o  = (r_state == ST_IDLE);
    assign valid_o  = r_valid;
    assign result_o = r_result;

endmodule : mul_byte_seq
`default_nettype wire

// File: tb/tb_mul_byte_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_byte_seq
//  Description : Self-checking bench for mul_byte_seq. Expected products come
//                from 64-bit sign/zero-extended arithmetic; expected latency
//                from the highest nonzero multiplier byte when
//                MUL_EARLY_EXIT_EN is defined, otherwise a fixed 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_byte_seq;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        ready_o;
    logic [1:0]  op_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_byte_seq dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .op_i        (op_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .result_o    (result_o)
    );

    // Reference product: extend operands per RV32M signedness, multiply in 64 bits
    function automatic logic [31:0] model_result(input logic [1:0] op,
                                                 input logic [31:0] a,
                                                 input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Reference latency from acceptance edge to valid_o
    function automatic int model_latency(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int          hi;
        m  = (op == 2'b01 && b[31]) ? (32'd0 - b) : b;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (((m >> (8 * i)) & 32'hFF) != 0) hi = i;
        end
        return EARLY_EXIT ? (2 + hi) : 5;
    endfunction

    // Issue one request (time = just after a rising edge), wait for valid_o.
    // Inputs are scrambled while busy; lat = 99 if valid_o never appears.
    task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic acc_ok, output logic [31:0] res, output int lat);
        valid_i     = 1'b1;
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        acc_ok      = ready_o;
        @(posedge clk); #1;
        lat = 0;
        while (!valid_o && lat < 30) begin
            valid_i     = 1'($urandom);
            op_i        = 2'($urandom);
            operand_a_i = $urandom;
            operand_b_i = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        if (!valid_o) lat = 99;
        valid_i = 1'b0;
        res     = result_o;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        op_i = 2'b00; operand_a_i = 32'd0; operand_b_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        total++; if (result_o !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
        rst_n_i = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic test_directed();
        vec_t        v[7];
        logic        ok;
        logic [31:0] res;
        int          lat;
        v[0] = '{2'b00, 32'd3,          32'd5,          32'h0000000F};
        v[1] = '{2'b11, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE};
        v[2] = '{2'b00, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001};
        v[3] = '{2'b01, 32'h80000000,   32'h80000000,   32'h40000000};
        v[4] = '{2'b00, 32'hFFFFFFFF,   32'd7,          32'hFFFFFFF9};
        v[5] = '{2'b10, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF};
        v[6] = '{2'b00, 32'd3,          32'h01000000,   32'h03000000};
        for (int i = 0; i < 7; i++) begin
            run_req(v[i].op, v[i].a, v[i].b, ok, res, lat);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL dir%0d_accept ready=%b want=1", i, ok); end
            total++; if (res !== v[i].exp) begin bad++; $display("FAIL dir%0d_result got=%h want=%h", i, res, v[i].exp); end
            total++; if (lat != model_latency(v[i].op, v[i].b)) begin
                bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, model_latency(v[i].op, v[i].b));
            end
            total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL dir%0d_busy ready=%b want=0", i, ready_o); end
            ready_i = 1'b1;
            @(posedge clk); #1;
            ready_i = 1'b0;
            total++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                bad++; $display("FAIL dir%0d_handshake valid=%b ready=%b want valid=0 ready=1", i, valid_o, ready_o);
            end
        end
    endtask

    task automatic test_backpressure();
        logic        ok;
        logic [31:0] res;
        int          lat;
        run_req(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, ok, res, lat);
        total++; if (res !== 32'hFFFFFFFF) begin bad++; $display("FAIL bp_result got=%h want=ffffffff", res); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (valid_o !== 1'b1 || result_o !== 32'hFFFFFFFF || ready_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d valid=%b result=%h ready=%b want 1/ffffffff/0", c, valid_o, result_o, ready_o);
            end
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL bp_release valid=%b want=0", valid_o); end
    endtask

    task automatic test_midreset();
        logic        ok;
        logic [31:0] res;
        int          lat;
        int          seen;
        valid_i = 1'b1; op_i = 2'b00; operand_a_i = 32'd9; operand_b_i = 32'd9;
        @(posedge clk); #1;          // accepted
        valid_i = 1'b0;
        @(posedge clk); #1;          // second ITER cycle
        rst_n_i = 1'b0;
        @(posedge clk); #1;
        rst_n_i = 1'b1;
        total++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'd0) begin
            bad++; $display("FAIL midrst_state valid=%b ready=%b result=%h want 0/1/0", valid_o, ready_o, result_o);
        end
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (valid_o) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midrst_dropped valid_cycles=%0d want=0", seen); end
        run_req(2'b00, 32'd3, 32'd5, ok, res, lat);
        total++; if (res !== 32'h0000000F) begin bad++; $display("FAIL midrst_next got=%h want=0000000f", res); end
        total++; if (lat != model_latency(2'b00, 32'd5)) begin
            bad++; $display("FAIL midrst_latency got=%0d want=%0d", lat, model_latency(2'b00, 32'd5));
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        ok;
        logic [31:0] res;
        int          lat;
        run_req(2'b11, 32'h12345678, 32'h9ABCDEF0, ok, res, lat);
        total++; if (res !== model_result(2'b11, 32'h12345678, 32'h9ABCDEF0)) begin
            bad++; $display("FAIL b2b_first got=%h want=%h", res, model_result(2'b11, 32'h12345678, 32'h9ABCDEF0));
        end
        // New request offered in the same cycle the result handshakes
        ready_i = 1'b1; valid_i = 1'b1; op_i = 2'b01;
        operand_a_i = 32'hDEADBEEF; operand_b_i = 32'h00000123;
        @(posedge clk); #1;
        ready_i = 1'b0;
        total++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++; $display("FAIL b2b_no_same_cycle ready=%b valid=%b want 1/0", ready_o, valid_o);
        end
        run_req(2'b01, 32'hDEADBEEF, 32'h00000123, ok, res, lat);
        total++; if (res !== model_result(2'b01, 32'hDEADBEEF, 32'h00000123)) begin
            bad++; $display("FAIL b2b_second got=%h want=%h", res, model_result(2'b01, 32'hDEADBEEF, 32'h00000123));
        end
        total++; if (lat != model_latency(2'b01, 32'h00000123)) begin
            bad++; $display("FAIL b2b_latency got=%0d want=%0d", lat, model_latency(2'b01, 32'h00000123));
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 255)) << (8 * $urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic        ok;
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            run_req(op, a, b, ok, res, lat);
            total++; if (ok !== 1'b1 || res !== model_result(op, a, b)) begin
                bad++;
                $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h accepted=%b",
                         i, op, a, b, res, model_result(op, a, b), ok);
            end
            total++; if (lat != model_latency(op, b)) begin
                bad++; $display("FAIL rnd%0d_latency op=%0d b=%h got=%0d want=%0d", i, op, b, lat, model_latency(op, b));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            ready_i = 1'b1;
            @(posedge clk); #1;
            ready_i = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_midreset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule : tb_mul_byte_seq
`default_nettype wire
